// File: rtl/mem_bus_pkg.sv
// Shared address map and decode helpers for the memory-bus responder.
// IO lives at address bits [17:16] == 2'b11; the two registers are the data
// port (TX push / RX pop) and the status/halt register.
package mem_bus_pkg;

    localparam int          IO_DEC_WIDTH   = 18;
    localparam logic [1:0]  IO_SPACE_SEL   = 2'b11;
    localparam logic [17:0] IO_BASE_ADDR   = 18'h3_0000;
    localparam logic [17:0] IO_STATUS_ADDR = 18'h3_0004;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_IO_DATA,
        SEL_IO_STATUS,
        SEL_IO_NONE
    } sel_e;

    // Classify an access by the low address bits; upper bits never matter.
    function automatic sel_e decode(input logic [IO_DEC_WIDTH-1:0] a);
        if (a[17:16] != IO_SPACE_SEL) return SEL_RAM;
        if (a == IO_BASE_ADDR)        return SEL_IO_DATA;
        if (a == IO_STATUS_ADDR)      return SEL_IO_STATUS;
        return SEL_IO_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Bus bundle between a memory controller / byte-stream peers and the responder.
// master = controller and stream peers (testbench side); slave = responder.
// Clock, reset and the global enable stay as plain ports on the modules.
interface mem_bus_responder_if;

    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready;
    logic [7:0]  io_rx_data;
    logic        io_rx_valid;
    logic        io_rx_ready;
    logic        tx_overflow;
    logic        halt;

    modport master (
        output mem_a, mem_wr, mem_wdata, io_tx_ready, io_rx_data, io_rx_valid,
        input  mem_rdata, io_tx_data, io_tx_valid, io_rx_ready, tx_overflow, halt
    );

    modport slave (
        input  mem_a, mem_wr, mem_wdata, io_tx_ready, io_rx_data, io_rx_valid,
        output mem_rdata, io_tx_data, io_tx_valid, io_rx_ready, tx_overflow, halt
    );

endinterface

// File: rtl/byte_fifo.sv
// Purpose: small synchronous FIFO with first-word fall-through head output.
// Latency: a pushed word is visible at dout the cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop_en;
    logic             push_en;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Purpose: byte RAM plus optional TX FIFO / RX holding register IO (MEM_BUS_IO_EN).
// Latency: writes commit at the access edge; read data is registered, one edge.
// Backpressure: none on the bus; rdy_in low freezes state, TX drops on full.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    mem_bus_responder_if.slave  bus
);

    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic [7:0]                ram [2**RAM_ADDR_WIDTH];
    logic                      wr_en;
    logic                      rd_en;
    logic                      ram_sel;
    logic [7:0]                rd_mux;
    logic [7:0]                rdata_q;

    assign ram_idx       = bus.mem_a[RAM_ADDR_WIDTH-1:0];
    assign wr_en         = rdy_in && bus.mem_wr;
    assign rd_en         = rdy_in && !bus.mem_wr;
    assign bus.mem_rdata = rdata_q;

    // RAM write port; contents are deliberately left uninitialised by reset.
    always_ff @(posedge clk_in) begin
        if (wr_en && ram_sel && !rst_in) ram[ram_idx] <= bus.mem_wdata;
    end

    // Read data register: updated only on read edges, otherwise held.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)     rdata_q <= 8'h00;
        else if (rd_en) rdata_q <= rd_mux;
    end

`ifdef MEM_BUS_IO_EN

    sel_e       sel;
    logic       tx_push;
    logic       tx_pop;
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;
    logic       rx_full;
    logic [7:0] rx_byte;
    logic       rx_cap;
    logic       rx_rd;
    logic       tx_ovf_q;
    logic       halt_q;
    logic       unused_bits;

    assign sel     = decode(bus.mem_a[IO_DEC_WIDTH-1:0]);
    assign ram_sel = (sel == SEL_RAM);
    assign tx_push = wr_en && (sel == SEL_IO_DATA);
    assign tx_pop  = rdy_in && !tx_empty && bus.io_tx_ready;
    // rx_full low is the ready condition, so a capture never overwrites a held byte.
    assign rx_cap  = rdy_in && bus.io_rx_valid && !rx_full;
    assign rx_rd   = rd_en && (sel == SEL_IO_DATA);

    assign bus.io_tx_data  = tx_head;
    assign bus.io_tx_valid = !tx_empty;
    assign bus.io_rx_ready = !rx_full;
    assign bus.tx_overflow = tx_ovf_q;
    assign bus.halt        = halt_q;
    assign unused_bits     = ^bus.mem_a[31:RAM_ADDR_WIDTH];

    byte_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (tx_push),
        .din   (bus.mem_wdata),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Read mux: RAM byte or IO register view sampled before this edge's updates.
    always_comb begin
        rd_mux = ram[ram_idx];
        case (sel)
            SEL_IO_DATA:   rd_mux = rx_full ? rx_byte : 8'h00;
            SEL_IO_STATUS: rd_mux = {6'b0, rx_full, tx_full};
            SEL_IO_NONE:   rd_mux = 8'h00;
            default:       rd_mux = ram[ram_idx];
        endcase
    end

    // RX holding register: a read empties it, a capture (only when empty) fills it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_full <= 1'b0;
            rx_byte <= 8'h00;
        end else begin
            if (rx_rd) rx_full <= 1'b0;
            if (rx_cap) begin
                rx_full <= 1'b1;
                rx_byte <= bus.io_rx_data;
            end
        end
    end

    // Sticky flags: overflow on a refused push, halt on a status-register write.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_ovf_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            if (tx_push && tx_full && !tx_pop)       tx_ovf_q <= 1'b1;
            if (wr_en && (sel == SEL_IO_STATUS))     halt_q   <= 1'b1;
        end
    end

`else

    logic unused_bits;

    assign ram_sel         = 1'b1;
    assign bus.io_tx_data  = 8'h00;
    assign bus.io_tx_valid = 1'b0;
    assign bus.io_rx_ready = 1'b0;
    assign bus.tx_overflow = 1'b0;
    assign bus.halt        = 1'b0;
    assign unused_bits     = ^{bus.mem_a[31:RAM_ADDR_WIDTH], bus.io_tx_ready,
                               bus.io_rx_data, bus.io_rx_valid};

    // Read mux: every address is RAM in this build.
    always_comb begin
        rd_mux = ram[ram_idx];
    end

`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed scenarios followed by random traffic.
// A reference model updates at each clock edge and queues expected read data;
// independent monitors compare read data and the IO/flag outputs.
module tb_mem_bus_responder;

`ifdef MEM_BUS_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif
    localparam int DEPTH = 8;
    localparam int RAW   = 17;
    localparam logic [31:0] A_DATA   = 32'h0003_0000;
    localparam logic [31:0] A_STATUS = 32'h0003_0004;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;

    mem_bus_responder_if bus();

    mem_bus_responder #(
        .RAM_ADDR_WIDTH (RAW),
        .TX_DEPTH       (DEPTH)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ram_m [int];
    logic [7:0] tx_q [$];
    logic [7:0] rd_q [$];
    bit         rx_full_m   = 1'b0;
    logic [7:0] rx_byte_m   = 8'h00;
    bit         ovf_m       = 1'b0;
    bit         halt_m      = 1'b0;
    logic [7:0] rdata_m     = 8'h00;
    bit         rdata_known = 1'b1;
    bit         old_rx_full;
    bit         old_tx_full;
    int         kind;
    int         idx;

    // 0 = RAM, 1 = data port, 2 = status, 3 = unmapped IO
    function automatic int classify(input logic [31:0] a);
        if (!IO_EN || a[17:16] != 2'b11) return 0;
        if (a[17:0] == 18'h30000) return 1;
        if (a[17:0] == 18'h30004) return 2;
        return 3;
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_q.delete();
            rd_q.delete();
            rx_full_m   = 1'b0;
            ovf_m       = 1'b0;
            halt_m      = 1'b0;
            rdata_m     = 8'h00;
            rdata_known = 1'b1;
        end else begin
            if (rdy_in) begin
                old_rx_full = rx_full_m;
                old_tx_full = (tx_q.size() == DEPTH);
                if (IO_EN && tx_q.size() > 0 && bus.io_tx_ready) void'(tx_q.pop_front());
                kind = classify(bus.mem_a);
                idx  = int'(bus.mem_a[RAW-1:0]);
                if (bus.mem_wr) begin
                    case (kind)
                        0: ram_m[idx] = bus.mem_wdata;
                        1: if (tx_q.size() < DEPTH) tx_q.push_back(bus.mem_wdata);
                           else ovf_m = 1'b1;
                        2: halt_m = 1'b1;
                        default: ;
                    endcase
                end else begin
                    rdata_known = 1'b1;
                    case (kind)
                        0: if (ram_m.exists(idx)) rdata_m = ram_m[idx];
                           else rdata_known = 1'b0;
                        1: begin
                            rdata_m   = old_rx_full ? rx_byte_m : 8'h00;
                            rx_full_m = 1'b0;
                        end
                        2: rdata_m = {6'b0, old_rx_full, old_tx_full};
                        default: rdata_m = 8'h00;
                    endcase
                end
                if (IO_EN && bus.io_rx_valid && !old_rx_full) begin
                    rx_byte_m = bus.io_rx_data;
                    rx_full_m = 1'b1;
                end
            end
            if (rdata_known) rd_q.push_back(rdata_m);
        end
    end

    // ---------------- monitors ----------------
    // Read-data scoreboard: each edge's expected mem_rdata, checked just after the edge.
    always begin
        @(posedge clk_in);
        #1;
        if (rd_q.size() > 0) check("mem_rdata", bus.mem_rdata, rd_q.pop_front());
    end

    // IO and sticky-flag outputs, checked mid-cycle against the model state.
    always @(negedge clk_in) begin
        check("io_tx_valid", bus.io_tx_valid, tx_q.size() != 0);
        check("io_rx_ready", bus.io_rx_ready, IO_EN && !rx_full_m);
        check("tx_overflow", bus.tx_overflow, ovf_m);
        check("halt", bus.halt, halt_m);
        if (tx_q.size() != 0)  check("io_tx_data", bus.io_tx_data, tx_q[0]);
        else if (!IO_EN)       check("io_tx_data_tied", bus.io_tx_data, 8'h00);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit wr, input logic [31:0] a, input logic [7:0] d);
        bus.mem_wr    = wr;
        bus.mem_a     = a;
        bus.mem_wdata = d;
        @(negedge clk_in);
    endtask

    logic [31:0] ra;
    int          r;

    initial begin
        bus.mem_a       = 32'h0;
        bus.mem_wr      = 1'b0;
        bus.mem_wdata   = 8'h00;
        bus.io_tx_ready = 1'b0;
        bus.io_rx_data  = 8'h00;
        bus.io_rx_valid = 1'b0;
        rdy_in          = 1'b1;
        #3 rst_in = 1'b1;
        #1;
        check("reset_rdata", bus.mem_rdata, 8'h00);
        check("reset_halt", bus.halt, 1'b0);
        check("reset_ovf", bus.tx_overflow, 1'b0);
        check("reset_tx_valid", bus.io_tx_valid, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b0;
        drive(1, 32'h0, 8'h00);

        // RAM write then read: A5 one edge after the read
        drive(1, 32'h10, 8'hA5);
        drive(0, 32'h10, 8'h00);
        check("ram_read_a5", bus.mem_rdata, 8'hA5);
        drive(0, 32'h0, 8'h00);

        // Nine TX pushes with the sink stalled, then drain
        bus.io_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) drive(1, A_DATA, 8'h60 + 8'(i));
        check("ovf_after_9", bus.tx_overflow, IO_EN);
        bus.io_tx_ready = 1'b1;
        repeat (10) drive(0, 32'h0, 8'h00);

        // RX byte 0x41 offered, read twice
        bus.io_rx_data  = 8'h41;
        bus.io_rx_valid = 1'b1;
        drive(0, 32'h0, 8'h00);
        bus.io_rx_valid = 1'b0;
        drive(0, A_DATA, 8'h00);
        drive(0, A_DATA, 8'h00);
        drive(0, 32'h0, 8'h00);

        // Enable low during a write: RAM unchanged, read data held
        drive(1, 32'h20, 8'h33);
        drive(0, 32'h10, 8'h00);
        rdy_in = 1'b0;
        drive(1, 32'h20, 8'hCC);
        check("held_rdata", bus.mem_rdata, 8'hA5);
        rdy_in = 1'b1;
        drive(0, 32'h20, 8'h00);
        check("ram_unchanged", bus.mem_rdata, 8'h33);

        // Halt then reset pulse in the middle of a read cycle
        drive(1, A_STATUS, 8'h01);
        bus.mem_wr = 1'b0;
        bus.mem_a  = 32'h10;
        @(posedge clk_in);
        #2;
        check("halt_set", bus.halt, IO_EN);
        rst_in = 1'b1;
        #1;
        check("mid_reset_rdata", bus.mem_rdata, 8'h00);
        check("mid_reset_halt", bus.halt, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b0;
        drive(0, 32'h0, 8'h00);

        // Data-port address write then read (RAM alias when IO is disabled)
        drive(1, A_DATA, 8'h7E);
        drive(0, A_DATA, 8'h00);
        check("data_port_read", bus.mem_rdata, IO_EN ? 8'h00 : 8'h7E);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rdy_in          = ($urandom_range(0, 9) != 0);
            bus.io_tx_ready = ($urandom_range(0, 2) != 0);
            bus.io_rx_valid = ($urandom_range(0, 3) == 0);
            bus.io_rx_data  = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r <= 5)
                ra = ($urandom & 32'hFFFC_0000) | ($urandom_range(0, 1) ? 32'h1_0000 : 32'h0)
                     | 32'($urandom_range(0, 15));
            else if (r <= 7) ra = A_DATA;
            else if (r == 8) ra = A_STATUS;
            else             ra = $urandom_range(0, 1) ? 32'h0003_0008 : 32'h0003_FFFF;
            drive(($urandom_range(0, 1) == 1), ra, 8'($urandom));
        end

        rdy_in          = 1'b1;
        bus.io_tx_ready = 1'b1;
        bus.io_rx_valid = 1'b0;
        repeat (12) drive(0, 32'h0, 8'h00);
        check("drained", bus.io_tx_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, 17, byte-address width of backing RAM (2^17 bytes).
REQ-002 SHALL have parameter TX_DEPTH, 8, TX FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk_in  input  1  the single clock, rising-edge active.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-006 SHALL have port mem_a  input  32  byte address from the memory controller.
REQ-007 SHALL have port mem_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port mem_wdata  input  8  write byte (controller data output bus).
REQ-009 SHALL have port mem_rdata  output  8  registered read byte (controller data input bus).
REQ-010 SHALL have port io_tx_data  output  8  TX FIFO head byte.
REQ-011 SHALL have port io_tx_valid  output  1  TX FIFO non-empty.
REQ-012 SHALL have port io_tx_ready  input  1  sink accepts head byte this cycle.
REQ-013 SHALL have port io_rx_data  input  8  incoming byte.
REQ-014 SHALL have port io_rx_valid  input  1  incoming byte offered.
REQ-015 SHALL have port io_rx_ready  output  1  RX holding register empty.
REQ-016 SHALL have port tx_overflow  output  1  sticky: TX write dropped on full.
REQ-017 SHALL have port halt  output  1  sticky: program-end write seen.

Function
REQ-018 SHALL decode IO space as mem_a[17:16]==2'b11; all other addresses SHALL map to RAM at mem_a[RAM_ADDR_WIDTH-1:0] (upper bits ignored, wrap).
REQ-019 SHALL, with rdy_in high and mem_wr high on edge N, commit mem_wdata at edge N; RAM write occurs only for RAM space.
REQ-020 SHALL, with rdy_in high and mem_wr low on edge N, present the addressed byte on mem_rdata after edge N (one-cycle latency), held until the next read edge.
REQ-021 SHALL, on a write to 0x30000, push mem_wdata into the TX FIFO; if full and no same-cycle pop, drop it and set tx_overflow.
REQ-022 SHALL pop the TX FIFO on an edge where io_tx_valid and io_tx_ready are both high; simultaneous push and pop when full SHALL accept the push.
REQ-023 SHALL capture io_rx_data into the RX holding register on an edge where io_rx_valid and io_rx_ready are high.
REQ-024 SHALL, on a read of 0x30000, return the held RX byte and mark the register empty, or return 8'h00 when empty; a same-edge capture and read SHALL return the old value (or 00) and leave the new byte held.
REQ-025 SHALL, on a read of 0x30004, return {6'b0, rx_full, tx_full}.
REQ-026 SHALL, on a write to 0x30004, set halt; further writes SHALL still be serviced.
REQ-027 SHALL return 8'h00 for reads of unmapped IO addresses and ignore writes to them.
REQ-028 SHALL, with rdy_in low, perform no RAM write, FIFO push/pop, RX capture or flag update, and hold mem_rdata.

Reset
REQ-029 SHALL, on rst_in high at any time including mid-access, immediately clear mem_rdata to 00, TX pointers/count, RX holding register (empty), tx_overflow and halt.
REQ-030 SHALL not initialise RAM contents on reset.

Configuration
REQ-031 SHALL, with MEM_BUS_IO_EN defined, implement REQ-018 and REQ-021..REQ-027 as specified.
REQ-032 SHALL, without MEM_BUS_IO_EN, map every address to RAM, tie io_tx_valid, io_rx_ready, tx_overflow and halt low, and drive io_tx_data to 00.

Structure
REQ-033 SHALL take IO base 0x30000, status address 0x30004 and the IO-space decode constant from shared package mem_bus_pkg.
REQ-034 SHALL implement the TX FIFO as sub-module byte_fifo (parameterised depth, push/pop/full/empty).

Verification
REQ-035 SHALL cover: write 0xA5 to 0x00010, read 0x00010 -> mem_rdata==A5 one edge after read address.
REQ-036 SHALL cover: 9 writes to 0x30000 with io_tx_ready low (depth 8) -> 8 queued, tx_overflow=1; then ready high -> bytes out in order.
REQ-037 SHALL cover: io_rx_data=0x41 offered, read 0x30000 -> 41, second read -> 00, io_rx_ready returns high.
REQ-038 SHALL cover: rdy_in low during write to 0x00020 -> RAM unchanged, mem_rdata held.
REQ-039 SHALL cover: write to 0x30004 then rst_in pulse mid-read -> halt=1 then 0, mem_rdata=00 immediately.
REQ-040 SHALL cover: build without MEM_BUS_IO_EN, write 0x7E to 0x30000, read back -> 7E from RAM.
